// File: rtl/serial_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_divider_pkg
//  Description : Shared types and constants for the serial divider core and
//                the Wishbone project stage that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_divider_pkg;

    // Divider control states; encoding is shared with the LA display.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Logic-analyser select codes used by the project stage.
    localparam logic [1:0] SELDIVISOR   = 2'd0;
    localparam logic [1:0] SELDIVIDEND  = 2'd1;
    localparam logic [1:0] SELQUOTIENT  = 2'd2;
    localparam logic [1:0] SELREMAINDER = 2'd3;

endpackage
`default_nettype wire

// File: rtl/serial_divider_core.sv
`default_nettype none
// ============================================================================
//  Module      : serial_divider_core
//  Description : Unsigned restoring radix-2 divider, one quotient bit per
//                clock. Divide-by-zero completes in a single cycle with an
//                all-ones quotient and the dividend as remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_divider_core
    import serial_divider_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            fini_o,
    output logic            dbz_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    div_state_t        r_state;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [CNTW-1:0]   r_cnt;

    logic              w_accept;
    logic              w_div_zero;
    logic              w_last;
    logic [2*XLEN-1:0] w_shift;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_q;
    logic [XLEN:0]     w_t;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;

    // Starts are only honoured outside CALC; a running division cannot be
    // restarted or queued behind.
    assign w_accept   = start_i && (r_state != CALC);
    assign w_div_zero = (divisor_i == '0);
    assign w_last     = (r_state == CALC) && (r_cnt == '0);

    // One restoring step. The partial remainder after k steps is below 2^k,
    // so the shift never loses a significant bit before the final step.
    assign w_shift    = {r_rem, r_quo} << 1;
    assign w_r        = w_shift[2*XLEN-1:XLEN];
    assign w_q        = w_shift[XLEN-1:0];
    assign w_t        = {1'b0, w_r} - {1'b0, r_div};
    assign w_rem_next = w_t[XLEN] ? w_r : w_t[XLEN-1:0];
    assign w_quo_next = {w_q[XLEN-1:1], ~w_t[XLEN]};

    // Control FSM with registered status flags.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
            fini_o  <= 1'b0;
            dbz_o   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (w_div_zero) begin
                            r_state <= DONE;
                            busy_o  <= 1'b0;
                            fini_o  <= 1'b1;
                            dbz_o   <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            busy_o  <= 1'b1;
                            fini_o  <= 1'b0;
                            dbz_o   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_state <= DONE;
                        busy_o  <= 1'b0;
                        fini_o  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                    fini_o  <= 1'b0;
                    dbz_o   <= 1'b0;
                end
            endcase
        end
    end

    // Working registers and result registers; results change only when an
    // operation completes so a new op in flight still shows the old result.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_div       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                quotient_o  <= '1;
                remainder_o <= dividend_i;
            end else begin
                r_div <= divisor_i;
                r_rem <= '0;
                r_quo <= dividend_i;
                r_cnt <= CNTW'(XLEN - 1);
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CNTW'(1);
            if (w_last) begin
                quotient_o  <= w_quo_next;
                remainder_o <= w_rem_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_divider_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_divider_core
//  Description : Scoreboard bench for serial_divider_core with directed
//                corner cases and randomized operands against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_divider_core;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic            dbz;
    } res_t;

    logic            clk;
    logic            reset_i;
    logic            start_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            busy_o;
    logic            fini_o;
    logic            dbz_o;
    logic [XLEN-1:0] quotient_o;
    logic [XLEN-1:0] remainder_o;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic acc_at_edge = 1'b0;
    logic prev_fini   = 1'b0;

    serial_divider_core #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .fini_o      (fini_o),
        .dbz_o       (dbz_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain unsigned division with the divide-by-zero rule.
    function automatic res_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        res_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Remember whether an op was accepted at each edge (start while not busy),
    // so a divide-by-zero issued from DONE (fini stays high) is still seen.
    always @(posedge clk) acc_at_edge <= reset_i && start_i && !busy_o;

    // Monitor: pop and compare whenever a fresh result is presented.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (reset_i && fini_o && (!prev_fini || acc_at_edge)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", 64'(quotient_o), 64'(e.q));
                    check("remainder", 64'(remainder_o), 64'(e.r));
                    check("dbz", 64'(dbz_o), 64'(e.dbz));
                    check("busy_at_fini", 64'(busy_o), 64'd0);
                end
            end
            prev_fini = fini_o;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_fini"}, 64'(fini_o), 64'd0);
        check({tag, "_dbz"}, 64'(dbz_o), 64'd0);
        check({tag, "_quotient"}, 64'(quotient_o), 64'd0);
        check({tag, "_remainder"}, 64'(remainder_o), 64'd0);
    endtask

    // Issue one op with a single-cycle start pulse; check latency and busy
    // duration. glitch_at >= 0 pulses a second start at that CALC cycle.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int glitch_at);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start_i  = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!fini_o && cyc < 40) begin
            if (busy_o) busy_cnt++;
            if (cyc == glitch_at) begin
                dividend_i = 32'd9;
                divisor_i  = 32'd2;
                start_i    = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check("latency", 64'(cyc), (b == '0) ? 64'd0 : 64'(XLEN));
        check("busy_cycles", 64'(busy_cnt), (b == '0) ? 64'd0 : 64'(XLEN));
    endtask

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        int              cyc;

        reset_i    = 1'b0;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_i = 1'b1;

        // Directed cases.
        run_op(32'd100, 32'd25, -1);
        run_op(32'hFFFF_FFFF, 32'd1, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(32'd5, 32'd7, -1);
        run_op(32'd7, 32'd0, -1);
        run_op(32'd1000, 32'd3, 10);
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, -1);

        // Reset in the middle of CALC discards the op.
        @(negedge clk);
        dividend_i = 32'd100;
        divisor_i  = 32'd25;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_state("midcalc_reset");
        reset_i = 1'b1;
        run_op(32'd100, 32'd25, -1);

        // Back-to-back: start held high in DONE; old result must persist.
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        exp_q.push_back(model(32'd1000, 32'd3));
        @(negedge clk);
        check("b2b_fini_drop", 64'(fini_o), 64'd0);
        check("b2b_busy", 64'(busy_o), 64'd1);
        cyc = 0;
        while (!fini_o && cyc < 40) begin
            if (cyc == 16) check("b2b_old_quotient", 64'(quotient_o), 64'd4);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check("b2b_latency", 64'(cyc), 64'(XLEN));

        // Randomized operands.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                3:       b = a + 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(a, b, (i % 3 == 0) ? int'($urandom_range(0, 30)) : -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
